// File: rtl/display_pkg.sv
// Shared display constants and colour type used by the scan-out stage and the rasterizer.
package display_pkg;

  localparam int CORDW     = 16;
  localparam int COLRW     = 12;
  localparam int CHANW     = 4;
  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;

  localparam logic [COLRW-1:0] BG_COLR = 12'h137;

  typedef logic [11:0] colr_t;

endpackage

// File: rtl/sync_delay.sv
// Reset-cleared shift register that keeps sync and enable flags aligned with the colour read pipeline.
module sync_delay #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: integer-upscaled read address generation plus sync/colour alignment
// for the final VGA register stage.
module fb_scanout #(
  parameter int CORDW       = display_pkg::CORDW,
  parameter int FB_WIDTH    = display_pkg::FB_WIDTH,
  parameter int FB_HEIGHT   = display_pkg::FB_HEIGHT,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_ADDRW    = $clog2(FB_WIDTH * FB_HEIGHT),
  parameter int READ_LAT    = 2,
  parameter int COLRW       = display_pkg::COLRW,
  parameter logic [COLRW-1:0] BG_COLR = COLRW'(display_pkg::BG_COLR)
) (
  input  logic                    clk_pix,
  input  logic                    rstn,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic                    de,
  input  logic                    hsync,
  input  logic                    vsync,
  input  logic                    frame,
  output logic [FB_ADDRW-1:0]     fb_addr,
  output logic                    fb_read,
  input  logic [COLRW-1:0]        fb_colr,
  output logic                    out_hsync,
  output logic                    out_vsync,
  output logic                    out_de,
  output logic [COLRW-1:0]        out_colr
);

  import display_pkg::*;

  localparam int WIN_W = FB_WIDTH << SCALE_SHIFT;
  localparam int WIN_H = FB_HEIGHT << SCALE_SHIFT;
  localparam int SUBW  = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;

  localparam logic signed [CORDW-1:0] WIN_W_S    = CORDW'(WIN_W);
  localparam logic signed [CORDW-1:0] WIN_H_S    = CORDW'(WIN_H);
  localparam logic signed [CORDW-1:0] WIN_LAST_X = CORDW'(WIN_W - 1);
  localparam logic [SUBW-1:0]         SUB_MAX    = SUBW'((1 << SCALE_SHIFT) - 1);
  localparam logic [FB_ADDRW-1:0]     ROW_STEP   = FB_ADDRW'(FB_WIDTH);

  logic                armed, armed_nx;
  logic [FB_ADDRW-1:0] addr_row, addr_row_nx;
  logic [FB_ADDRW-1:0] addr_cur, addr_cur_nx;
  logic [SUBW-1:0]     sub_x, sub_x_nx;
  logic [SUBW-1:0]     sub_y, sub_y_nx;
  logic                in_fb;
  logic                line_end;
  logic [3:0]          dly;

  // Sign bits reject blanking coordinates before the upper-bound compares.
  assign in_fb = armed && de
                 && !sx[CORDW-1] && (sx < WIN_W_S)
                 && !sy[CORDW-1] && (sy < WIN_H_S);
  assign line_end = (sx == WIN_LAST_X);

  always_comb begin
    armed_nx    = armed;
    addr_row_nx = addr_row;
    addr_cur_nx = addr_cur;
    sub_x_nx    = sub_x;
    sub_y_nx    = sub_y;
    if (frame) begin
      armed_nx    = 1'b1;
      addr_row_nx = '0;
      addr_cur_nx = '0;
      sub_x_nx    = '0;
      sub_y_nx    = '0;
    end else if (in_fb) begin
      if (line_end) begin
        // End of a screen line either repeats the fb row or steps to the next one.
        sub_x_nx = '0;
        if (sub_y == SUB_MAX) begin
          sub_y_nx    = '0;
          addr_row_nx = addr_row + ROW_STEP;
          addr_cur_nx = addr_row + ROW_STEP;
        end else begin
          sub_y_nx    = sub_y + 1'b1;
          addr_cur_nx = addr_row;
        end
      end else if (sub_x == SUB_MAX) begin
        sub_x_nx    = '0;
        addr_cur_nx = addr_cur + 1'b1;
      end else begin
        sub_x_nx = sub_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      armed    <= 1'b0;
      addr_row <= '0;
      addr_cur <= '0;
      sub_x    <= '0;
      sub_y    <= '0;
      fb_addr  <= '0;
      fb_read  <= 1'b0;
    end else begin
      armed    <= armed_nx;
      addr_row <= addr_row_nx;
      addr_cur <= addr_cur_nx;
      sub_x    <= sub_x_nx;
      sub_y    <= sub_y_nx;
      fb_read  <= in_fb;
      if (in_fb) fb_addr <= addr_cur;
    end
  end

  sync_delay #(
    .WIDTH (4),
    .DEPTH (READ_LAT + 1)
  ) u_sync_delay (
    .clk  (clk_pix),
    .rstn (rstn),
    .din  ({hsync, vsync, de, in_fb}),
    .dout (dly)
  );

  // Final register stage: colour arrives here exactly when the delayed flags do.
  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_de    <= 1'b0;
      out_colr  <= '0;
    end else begin
      out_hsync <= dly[3];
      out_vsync <= dly[2];
      out_de    <= dly[1];
      if (!dly[1])     out_colr <= '0;
      else if (dly[0]) out_colr <= fb_colr;
      else             out_colr <= BG_COLR;
    end
  end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
Pixel-domain scan-out stage between display timing and the framebuffer/CLUT read path. It consumes sx/sy/de/sync from the 480p display generator and produces framebuffer read addresses with integer upscaling (160x120 to 640x480 by default). It also delays sync/de to match the read latency, so the final VGA register stage receives aligned colour and sync. Pixels outside the framebuffer window are painted with the background colour; blanking is painted black.

Parameters:
CORDW, 16, signed screen coordinate width
FB_WIDTH, 160, framebuffer width in pixels
FB_HEIGHT, 120, framebuffer height in pixels
SCALE_SHIFT, 2, log2 of upscale factor (scale = 4)
FB_ADDRW, $clog2(FB_WIDTH*FB_HEIGHT), read address width (15)
READ_LAT, 2, cycles from fb_addr to valid fb_colr (BRAM 1 + CLUT 1)
COLRW, 12, colour width (3x4-bit channels)
BG_COLR, 'h137, colour for active pixels outside the fb window

Ports:
clk_pix  in  1  pixel clock
rstn  in  1  asynchronous active-low reset
sx  in  CORDW  signed horizontal screen position
sy  in  CORDW  signed vertical screen position
de  in  1  data enable (active area)
hsync  in  1  horizontal sync
vsync  in  1  vertical sync
frame  in  1  one-cycle start-of-frame strobe
fb_addr  out  FB_ADDRW  framebuffer read address
fb_read  out  1  read enable, high when fb_addr is a valid fetch
fb_colr  in  COLRW  CLUT output, valid READ_LAT cycles after fb_addr
out_hsync  out  1  hsync delayed by READ_LAT+2
out_vsync  out  1  vsync delayed by READ_LAT+2
out_de  out  1  de delayed by READ_LAT+2
out_colr  out  COLRW  final pixel colour

Behaviour:
- Reset (rstn=0, async): fb_addr=0, fb_read=0, all out_* =0, counters (addr_row, addr_cur, sub_x, sub_y)=0, armed=0, delay lines cleared.
- Window: in_fb = armed & de & 0<=sx<FB_WIDTH<<SCALE_SHIFT & 0<=sy<FB_HEIGHT<<SCALE_SHIFT. Use signed compares; negative sx/sy (blanking) are never in_fb.
- frame strobe: addr_row, addr_cur, sub_x, sub_y <=0; armed<=1. frame wins over any simultaneous counter update.
- Unarmed after reset: no fetches (fb_read=0), output colour BG/black, until the first frame. This prevents a mid-frame reset from scanning out a misaligned image.
- Per in_fb cycle (registered, valid next cycle): fb_addr<=addr_cur, fb_read<=1. Then sub_x++; when sub_x==2^S-1, sub_x<=0 and addr_cur++.
- Last window pixel of a line (sx==(FB_WIDTH<<S)-1): sub_x<=0.
  - If sub_y==2^S-1: sub_y<=0, addr_row<=addr_row+FB_WIDTH, addr_cur<=addr_row+FB_WIDTH.
  - Else: sub_y++, addr_cur<=addr_row (row repeat).
  - This update overrides the per-pixel addr_cur increment.
- Not in_fb: fb_read<=0, fb_addr holds.
- Wrap: after the last row, addr_row reaches FB_WIDTH*FB_HEIGHT; it is never used because the next frame resets it. No modular arithmetic is required.
- Delay line: {hsync, vsync, de, in_fb} are shifted READ_LAT+1 stages, then the output register adds one more stage. Total latency from input sample to out_* is READ_LAT+2 (default 4).
- Colour mux (output register): out_colr = !de_d ? 0 : in_fb_d ? fb_colr : BG_COLR.
- fb_colr is sampled exactly READ_LAT cycles after the matching fb_addr.
- Latency is fixed and unconditional. There is no backpressure and no handshake beyond fb_read.

Decomposition:
- Shared package display_pkg: CORDW, COLRW, CHANW, FB_WIDTH, FB_HEIGHT, BG_COLR, and a typedef colr_t (logic [11:0]). The package is shared with the top level and the rasterizer.
- Sub-module sync_delay (parameters WIDTH, DEPTH): a reset-cleared shift register used for the {hsync, vsync, de, in_fb} alignment.
- Address generation stays in fb_scanout.

Test Plan:
- Reset low mid-line, release, no frame -> fb_read=0 for the whole line; out_colr=BG in active area, 0 in blanking.
- frame, then line sy=0, sx=0..639 -> fb_addr sequence 0,0,0,0,1,1,1,1,...,159 ×4. fb_read high for 640 cycles. First fb_addr appears 1 cycle after sx=0.
- Screen lines sy=0..3 -> each line restarts at addr 0. sy=4 starts at 160. sy=479 ends at 19199. Next frame returns to 0.
- Model CLUT returning colr = addr-tag with READ_LAT=2, hsync pulse at known sx -> out_colr at sx+4 equals the tag for that sx. out_hsync edge is exactly 4 cycles after the hsync edge.
- Reduced FB_WIDTH=80 window, sx=400 with de=1 -> out_colr='h137. Same sx with de=0 -> out_colr=0.
- frame asserted on the same cycle as the last-pixel-of-line condition -> counters all 0 next cycle and the next fetch is addr 0.
